// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the shared valid/ready memory bus.
// A grant is held for a whole transaction. A per-transaction watchdog
// completes hung accesses with an error word so the bus cannot deadlock.
module mem_bus_arbiter #(
   parameter int          TIMEOUT   = 64,
   parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF,
   parameter int          CNT_W     = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_valid,
   output logic        m0_ready,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   output logic        m1_ready,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic [31:0] m1_rdata,
   output logic        s_valid,
   input  logic        s_ready,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic [31:0] s_rdata,
   output logic        busy,
   output logic        err_stb,
   output logic        err_master,
   output logic [31:0] err_addr
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GNT0 = 2'd1,
      ST_GNT1 = 2'd2
   } state_t;

   // With the watchdog disabled the counter simply stays at zero.
   localparam logic             WDOG_EN  = (TIMEOUT > 0);
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   state_t           state_q;
   logic             last_grant_q;
   logic [CNT_W-1:0] cnt_q;
   logic             err_master_q;
   logic [31:0]      err_addr_q;

   logic gnt0, gnt1, gm_valid, timeout, handshake, done;

   assign gnt0     = (state_q == ST_GNT0);
   assign gnt1     = (state_q == ST_GNT1);
   assign gm_valid = (gnt0 & m0_valid) | (gnt1 & m1_valid);

   // Timeout fires only when the slave is still silent in the last allowed
   // cycle, so a slave answering in that very cycle completes normally.
   assign timeout   = WDOG_EN & gm_valid & ~s_ready & (cnt_q == CNT_LAST);
   assign s_valid   = gm_valid & ~timeout;
   assign handshake = s_valid & s_ready;
   assign done      = handshake | timeout;

   assign m0_ready   = gnt0 & done;
   assign m1_ready   = gnt1 & done;
   assign busy       = gnt0 | gnt1;
   assign err_stb    = timeout;
   assign err_master = err_master_q;
   assign err_addr   = err_addr_q;

   // Request and response muxing; the ungranted master always sees zero data.
   always_comb begin
      s_addr   = '0;
      s_wdata  = '0;
      s_wstrb  = '0;
      m0_rdata = '0;
      m1_rdata = '0;
      if (gnt0) begin
         s_addr   = m0_addr;
         s_wdata  = m0_wdata;
         s_wstrb  = m0_wstrb;
         m0_rdata = timeout ? ERR_RDATA : s_rdata;
      end else if (gnt1) begin
         s_addr   = m1_addr;
         s_wdata  = m1_wdata;
         s_wstrb  = m1_wstrb;
         m1_rdata = timeout ? ERR_RDATA : s_rdata;
      end
   end

   // Arbitration state, fairness pointer, watchdog counter and error capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         err_master_q <= 1'b0;
         err_addr_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_q <= '0;
               // On a tie the master that was not served last wins.
               if (m0_valid && (!m1_valid || last_grant_q)) begin
                  state_q <= ST_GNT0;
               end else if (m1_valid) begin
                  state_q <= ST_GNT1;
               end
            end
            default: begin
               if (!gm_valid) begin
                  // Master withdrew its request: abandon silently.
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
               end else if (done) begin
                  state_q      <= ST_IDLE;
                  last_grant_q <= gnt1;
                  cnt_q        <= '0;
                  if (timeout) begin
                     err_master_q <= gnt1;
                     err_addr_q   <= gnt1 ? m1_addr : m0_addr;
                  end
               end else if (cnt_q != CNT_LAST) begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus
// randomized two-master traffic against a transaction-level model.
module tb_mem_bus_arbiter;

   localparam int          TIMEOUT = 64;
   localparam logic [31:0] ERR     = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m0_valid = 0, m1_valid = 0;
   logic        m0_ready, m1_ready;
   logic [31:0] m0_addr = 0, m1_addr = 0, m0_wdata = 0, m1_wdata = 0;
   logic [3:0]  m0_wstrb = 0, m1_wstrb = 0;
   logic [31:0] m0_rdata, m1_rdata;
   logic        s_valid;
   logic        s_ready = 0;
   logic [31:0] s_addr, s_wdata;
   logic [3:0]  s_wstrb;
   logic [31:0] s_rdata = 0;
   logic        busy, err_stb, err_master;
   logic [31:0] err_addr;

   int n_checks = 0;
   int n_pass   = 0;

   // Slave behaviour knobs
   int          slave_lat  = 0;
   bit          idle_noise = 0;
   bit          use_fixed  = 0;
   logic [31:0] fixed_data = 0;
   int          wcnt       = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.TIMEOUT(TIMEOUT), .ERR_RDATA(ERR), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
      .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
      .busy(busy), .err_stb(err_stb), .err_master(err_master), .err_addr(err_addr)
   );

   function automatic logic [31:0] slave_word(input logic [31:0] a);
      return a ^ 32'h5A5A_C3C3;
   endfunction

   // Slave: answers after slave_lat waiting cycles of an active grant.
   initial begin
      forever begin
         @(negedge clk);
         if (busy === 1'b1) begin
            if (wcnt == slave_lat) begin
               s_ready = 1'b1;
               s_rdata = use_fixed ? fixed_data : slave_word(s_addr);
               wcnt    = 0;
            end else begin
               s_ready = 1'b0;
               s_rdata = $urandom;
               wcnt++;
            end
         end else begin
            wcnt    = 0;
            s_ready = idle_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            s_rdata = $urandom;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) step();
      sample();
      n_checks++; if (s_valid !== 1'b0) $display("FAIL rst_s_valid got=%0b exp=0", s_valid); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%0b exp=0", busy); else n_pass++;
      n_checks++; if ({m0_ready, m1_ready} !== 2'b00) $display("FAIL rst_ready got=%b exp=00", {m0_ready, m1_ready}); else n_pass++;
      n_checks++; if (err_stb !== 1'b0) $display("FAIL rst_err_stb got=%0b exp=0", err_stb); else n_pass++;
      n_checks++; if (err_master !== 1'b0) $display("FAIL rst_err_master got=%0b exp=0", err_master); else n_pass++;
      n_checks++; if (err_addr !== 32'h0) $display("FAIL rst_err_addr got=%h exp=0", err_addr); else n_pass++;
      step();
      rst = 1'b0;
   endtask

   task automatic test_round_robin();
      int n = 0;
      int last_c = 0;
      logic who;
      logic [31:0] got, exp;
      slave_lat = 0;
      step();
      m0_addr = 32'h0000_1000; m1_addr = 32'h8000_2000;
      m0_valid = 1'b1; m1_valid = 1'b1;
      for (int c = 0; c < 40 && n < 6; c++) begin
         sample();
         n_checks++; if ((m0_ready & m1_ready) !== 1'b0) $display("FAIL rr_both_ready cyc=%0d", c); else n_pass++;
         if (m0_ready === 1'b1 || m1_ready === 1'b1) begin
            who = m1_ready;
            got = who ? m1_rdata : m0_rdata;
            exp = slave_word(who ? m1_addr : m0_addr);
            n_checks++; if (who !== 1'(n % 2)) $display("FAIL rr_order idx=%0d got=m%0d exp=m%0d", n, who, n % 2); else n_pass++;
            n_checks++; if (got !== exp) $display("FAIL rr_rdata idx=%0d got=%h exp=%h", n, got, exp); else n_pass++;
            if (n > 0) begin
               n_checks++; if (c - last_c != 2) $display("FAIL rr_interval idx=%0d got=%0d exp=2", n, c - last_c); else n_pass++;
            end
            last_c = c;
            n++;
         end
         step();
      end
      n_checks++; if (n != 6) $display("FAIL rr_budget got=%0d completions exp=6", n); else n_pass++;
      m0_valid = 1'b0; m1_valid = 1'b0;
   endtask

   task automatic test_single_read();
      slave_lat = 2; use_fixed = 1'b1; fixed_data = 32'h1234_5678;
      step();
      m0_valid = 1'b1; m0_addr = 32'h0005_0000; m0_wstrb = 4'h0; m0_wdata = 32'h0;
      sample();
      n_checks++; if (s_valid !== 1'b0) $display("FAIL sr_arb_cycle s_valid got=%0b exp=0", s_valid); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         step();
         sample();
         n_checks++; if (s_valid !== 1'b1) $display("FAIL sr_s_valid i=%0d got=%0b exp=1", i, s_valid); else n_pass++;
         n_checks++; if (m0_ready !== (i == 2)) $display("FAIL sr_ready i=%0d got=%0b exp=%0b", i, m0_ready, i == 2); else n_pass++;
         if (i == 2) begin
            n_checks++; if (m0_rdata !== 32'h1234_5678) $display("FAIL sr_rdata got=%h exp=12345678", m0_rdata); else n_pass++;
         end
      end
      step();
      m0_valid = 1'b0;
      sample();
      n_checks++; if (busy !== 1'b0) $display("FAIL sr_busy_fall got=%0b exp=0", busy); else n_pass++;
      use_fixed = 1'b0;
   endtask

   task automatic test_write_passthrough();
      bit fin = 0;
      slave_lat = 1;
      step();
      m1_valid = 1'b1; m1_addr = 32'h0300_0004; m1_wdata = 32'hA5A5_A5A5; m1_wstrb = 4'b0011;
      sample();
      for (int i = 0; i < 10 && !fin; i++) begin
         step();
         sample();
         n_checks++; if (s_valid !== 1'b1) $display("FAIL wr_s_valid got=%0b exp=1", s_valid); else n_pass++;
         n_checks++; if (s_addr !== 32'h0300_0004) $display("FAIL wr_s_addr got=%h exp=03000004", s_addr); else n_pass++;
         n_checks++; if (s_wdata !== 32'hA5A5_A5A5) $display("FAIL wr_s_wdata got=%h exp=a5a5a5a5", s_wdata); else n_pass++;
         n_checks++; if (s_wstrb !== 4'b0011) $display("FAIL wr_s_wstrb got=%b exp=0011", s_wstrb); else n_pass++;
         n_checks++; if ({m0_ready, m0_rdata} !== 33'h0) $display("FAIL wr_m0_quiet ready=%0b rdata=%h exp=0/0", m0_ready, m0_rdata); else n_pass++;
         if (m1_ready === 1'b1) fin = 1;
      end
      n_checks++; if (fin != 1) $display("FAIL wr_budget got=no_ready exp=ready"); else n_pass++;
      step();
      m1_valid = 1'b0;
   endtask

   task automatic test_timeout();
      bit fin = 0;
      slave_lat = 1000;
      step();
      m0_valid = 1'b1; m0_addr = 32'h1000_0000; m0_wstrb = 4'h0;
      sample();
      for (int k = 1; k <= TIMEOUT; k++) begin
         step();
         if (k == 1) begin
            m1_valid = 1'b1; m1_addr = 32'h0300_0010; m1_wdata = 32'h0; m1_wstrb = 4'h0;
         end
         sample();
         n_checks++; if (m0_ready !== (k == TIMEOUT)) $display("FAIL to_ready k=%0d got=%0b exp=%0b", k, m0_ready, k == TIMEOUT); else n_pass++;
         n_checks++; if (err_stb !== (k == TIMEOUT)) $display("FAIL to_err_stb k=%0d got=%0b exp=%0b", k, err_stb, k == TIMEOUT); else n_pass++;
         n_checks++; if (s_valid !== (k != TIMEOUT)) $display("FAIL to_s_valid k=%0d got=%0b exp=%0b", k, s_valid, k != TIMEOUT); else n_pass++;
         if (k == TIMEOUT) begin
            n_checks++; if (m0_rdata !== ERR) $display("FAIL to_rdata got=%h exp=%h", m0_rdata, ERR); else n_pass++;
         end
      end
      step();
      m0_valid = 1'b0; slave_lat = 1;
      sample();
      n_checks++; if (busy !== 1'b0) $display("FAIL to_idle got=%0b exp=0", busy); else n_pass++;
      n_checks++; if (err_master !== 1'b0) $display("FAIL to_err_master got=%0b exp=0", err_master); else n_pass++;
      n_checks++; if (err_addr !== 32'h1000_0000) $display("FAIL to_err_addr got=%h exp=10000000", err_addr); else n_pass++;
      for (int i = 0; i < 6 && !fin; i++) begin
         step();
         sample();
         if (m1_ready === 1'b1) begin
            fin = 1;
            n_checks++; if (m1_rdata !== slave_word(32'h0300_0010)) $display("FAIL to_m1_rdata got=%h exp=%h", m1_rdata, slave_word(32'h0300_0010)); else n_pass++;
            n_checks++; if (err_stb !== 1'b0) $display("FAIL to_m1_err_stb got=%0b exp=0", err_stb); else n_pass++;
         end
      end
      n_checks++; if (fin != 1) $display("FAIL to_m1_budget got=no_ready exp=ready"); else n_pass++;
      step();
      m1_valid = 1'b0;
   endtask

   task automatic test_boundary();
      logic [31:0] a;
      for (int t = 0; t < 2; t++) begin
         a = (t == 0) ? 32'h2000_0040 : 32'h2000_0080;
         slave_lat = TIMEOUT - 1 + t;
         step();
         m1_valid = 1'b1; m1_addr = a; m1_wstrb = 4'h0;
         sample();
         for (int k = 1; k <= TIMEOUT; k++) begin
            step();
            sample();
            n_checks++; if (m1_ready !== (k == TIMEOUT)) $display("FAIL bd_ready t=%0d k=%0d got=%0b exp=%0b", t, k, m1_ready, k == TIMEOUT); else n_pass++;
            n_checks++; if (err_stb !== (t == 1 && k == TIMEOUT)) $display("FAIL bd_err_stb t=%0d k=%0d got=%0b", t, k, err_stb); else n_pass++;
            if (k == TIMEOUT) begin
               n_checks++; if (m1_rdata !== ((t == 0) ? slave_word(a) : ERR)) $display("FAIL bd_rdata t=%0d got=%h", t, m1_rdata); else n_pass++;
            end
         end
         step();
         m1_valid = 1'b0;
         sample();
         n_checks++; if (err_master !== 1'(t)) $display("FAIL bd_err_master t=%0d got=%0b exp=%0d", t, err_master, t); else n_pass++;
         n_checks++; if (err_addr !== ((t == 0) ? 32'h1000_0000 : a)) $display("FAIL bd_err_addr t=%0d got=%h", t, err_addr); else n_pass++;
      end
   endtask

   task automatic test_idle_ready_ignored();
      idle_noise = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         sample();
         n_checks++; if ({busy, m0_ready, m1_ready} !== 3'b000) $display("FAIL idle_noise i=%0d busy/r0/r1 got=%b exp=000", i, {busy, m0_ready, m1_ready}); else n_pass++;
      end
      idle_noise = 1'b0;
   endtask

   task automatic test_reset_mid_op();
      slave_lat = 1000;
      step();
      m1_valid = 1'b1; m1_addr = 32'h3000_0000; m1_wstrb = 4'h0;
      sample();
      repeat (3) begin step(); sample(); end
      n_checks++; if (busy !== 1'b1) $display("FAIL rm_waiting got=%0b exp=1", busy); else n_pass++;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0; slave_lat = 0;
      m0_valid = 1'b1; m0_addr = 32'h0000_0100; m0_wstrb = 4'h0;
      sample();
      n_checks++; if (s_valid !== 1'b0) $display("FAIL rm_s_valid got=%0b exp=0", s_valid); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rm_busy got=%0b exp=0", busy); else n_pass++;
      n_checks++; if ({err_master, err_addr} !== 33'h0) $display("FAIL rm_err_regs got=%0b/%h exp=0/0", err_master, err_addr); else n_pass++;
      step();
      sample();
      n_checks++; if (s_addr !== 32'h0000_0100) $display("FAIL rm_first_grant s_addr got=%h exp=00000100", s_addr); else n_pass++;
      n_checks++; if (m0_ready !== 1'b1) $display("FAIL rm_m0_ready got=%0b exp=1", m0_ready); else n_pass++;
      step();
      m0_valid = 1'b0;
      sample();
      step();
      sample();
      n_checks++; if (m1_ready !== 1'b1) $display("FAIL rm_m1_ready got=%0b exp=1", m1_ready); else n_pass++;
      n_checks++; if (m1_rdata !== slave_word(32'h3000_0000)) $display("FAIL rm_m1_rdata got=%h exp=%h", m1_rdata, slave_word(32'h3000_0000)); else n_pass++;
      step();
      m1_valid = 1'b0;
   endtask

   // Model: a free bus grants the sole requester (or, on a tie, the master not
   // served last); a grant lasts min(latency, TIMEOUT-1)+1 cycles.
   task automatic test_random_traffic();
      logic [31:0] ra[2], rw[2];
      logic [3:0]  rs[2];
      bit          pend[2];
      int          owner, left, mlast, lat, r, o;
      bit          to, fin;
      logic        exp_em, grdy, ordy;
      logic [31:0] exp_ea, grd, ord, exp_rd;
      for (int m = 0; m < 2; m++) begin ra[m] = 0; rw[m] = 0; rs[m] = 0; pend[m] = 0; end
      m0_valid = 1'b0; m1_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      idle_noise = 1'b1;
      owner = -1; left = 0; mlast = 1; to = 0; exp_em = 1'b0; exp_ea = 32'h0;
      for (int c = 0; c < 700; c++) begin
         for (int m = 0; m < 2; m++) begin
            if (!pend[m] && $urandom_range(0, 2) == 0) begin
               pend[m] = 1;
               ra[m] = {m[0], 29'($urandom), 2'b00};
               rw[m] = $urandom;
               rs[m] = 4'($urandom);
            end
         end
         m0_valid = pend[0]; m0_addr = ra[0]; m0_wdata = rw[0]; m0_wstrb = rs[0];
         m1_valid = pend[1]; m1_addr = ra[1]; m1_wdata = rw[1]; m1_wstrb = rs[1];
         if (owner < 0) begin
            r = $urandom_range(0, 9);
            if (r < 6)       lat = r % 3;
            else if (r == 6) lat = TIMEOUT - 1;
            else if (r == 7) lat = TIMEOUT;
            else if (r == 8) lat = 3 * TIMEOUT;
            else             lat = 1;
            slave_lat = lat;
         end
         sample();
         n_checks++; if (err_master !== exp_em || err_addr !== exp_ea) $display("FAIL rnd_err_regs cyc=%0d got=%0b/%h exp=%0b/%h", c, err_master, err_addr, exp_em, exp_ea); else n_pass++;
         if (owner < 0) begin
            n_checks++; if ({busy, s_valid, m0_ready, m1_ready, err_stb} !== 5'b0) $display("FAIL rnd_idle cyc=%0d busy/sv/r0/r1/es got=%b exp=00000", c, {busy, s_valid, m0_ready, m1_ready, err_stb}); else n_pass++;
            if (pend[0] || pend[1]) begin
               owner = (pend[0] && pend[1]) ? 1 - mlast : (pend[0] ? 0 : 1);
               to    = (slave_lat >= TIMEOUT);
               left  = to ? TIMEOUT : slave_lat + 1;
            end
         end else begin
            o = owner;
            left--;
            fin  = (left == 0);
            grdy = (o == 0) ? m0_ready : m1_ready;
            grd  = (o == 0) ? m0_rdata : m1_rdata;
            ordy = (o == 0) ? m1_ready : m0_ready;
            ord  = (o == 0) ? m1_rdata : m0_rdata;
            n_checks++; if (busy !== 1'b1) $display("FAIL rnd_busy cyc=%0d got=%0b exp=1", c, busy); else n_pass++;
            n_checks++; if ({s_addr, s_wdata, s_wstrb} !== {ra[o], rw[o], rs[o]}) $display("FAIL rnd_mux cyc=%0d m%0d got=%h/%h/%h exp=%h/%h/%h", c, o, s_addr, s_wdata, s_wstrb, ra[o], rw[o], rs[o]); else n_pass++;
            n_checks++; if (s_valid !== !(fin && to)) $display("FAIL rnd_s_valid cyc=%0d got=%0b exp=%0b", c, s_valid, !(fin && to)); else n_pass++;
            n_checks++; if (grdy !== fin) $display("FAIL rnd_ready cyc=%0d m%0d got=%0b exp=%0b", c, o, grdy, fin); else n_pass++;
            n_checks++; if ({ordy, ord} !== 33'h0) $display("FAIL rnd_other cyc=%0d got=%0b/%h exp=0/0", c, ordy, ord); else n_pass++;
            n_checks++; if (err_stb !== (fin && to)) $display("FAIL rnd_err_stb cyc=%0d got=%0b exp=%0b", c, err_stb, fin && to); else n_pass++;
            if (fin) begin
               exp_rd = to ? ERR : slave_word(ra[o]);
               n_checks++; if (grd !== exp_rd) $display("FAIL rnd_rdata cyc=%0d m%0d got=%h exp=%h", c, o, grd, exp_rd); else n_pass++;
               pend[o] = 0;
               mlast = o;
               if (to) begin exp_em = o[0]; exp_ea = ra[o]; end
               owner = -1;
            end
         end
         step();
      end
      m0_valid = 1'b0; m1_valid = 1'b0;
      idle_noise = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      test_reset();
      test_round_robin();
      test_single_read();
      test_write_passthrough();
      test_timeout();
      test_boundary();
      test_idle_ready_ignored();
      test_reset_mid_op();
      test_random_traffic();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
